// File: rtl/fib_lpm_lookup_pkg.sv
// Shared widths, route entry layout and prefix-mask helper for the LPM forwarding table.
package fib_lpm_lookup_pkg;

  localparam int unsigned IP_W   = 32;
  localparam int unsigned MAC_W  = 48;
  localparam int unsigned PLEN_W = 6;
  localparam int unsigned PORT_W = 4;

  localparam logic [PORT_W-1:0] NIC_PORT_DEF = 4'hF;
  localparam logic [PLEN_W-1:0] PLEN_MAX     = 6'd32;

  typedef struct packed {
    logic [IP_W-1:0]   prefix;
    logic [PLEN_W-1:0] plen;
    logic [IP_W-1:0]   nexthop;
    logic [MAC_W-1:0]  dmac;
    logic [PORT_W-1:0] port;
  } fib_route_t;

  typedef struct packed {
    logic       valid;
    fib_route_t route;
  } fib_entry_t;

  // Network mask with the top plen bits set; plen 0 is the default route.
  function automatic logic [IP_W-1:0] plen_mask(input logic [PLEN_W-1:0] plen);
    if (plen == '0) return '0;
    return ~({IP_W{1'b1}} >> plen);
  endfunction

endpackage

// File: rtl/fib_lpm_lookup_entry_ram.sv
// Route table storage: one synchronous write port, one asynchronous read port.
// Valid bits sit in a resettable vector so a reset empties the table without clearing payloads.
module fib_lpm_lookup_entry_ram
  import fib_lpm_lookup_pkg::*;
#(
  parameter int unsigned Entries = 16,
  parameter int unsigned IdxW    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [IdxW-1:0] i_waddr,
  input  fib_entry_t      i_wdata,
  input  logic [IdxW-1:0] i_raddr,
  output fib_entry_t      o_rdata
);

  fib_route_t         r_mem [Entries];
  logic [Entries-1:0] r_valid;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata.route;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_waddr] <= i_wdata.valid;
    end
  end

  always_comb begin
    o_rdata       = '0;
    o_rdata.valid = r_valid[i_raddr];
    o_rdata.route = r_mem[i_raddr];
  end

endmodule

// File: rtl/fib_lpm_lookup.sv
// Longest-prefix-match FIB lookup: scans one table entry per cycle and returns the
// next hop, egress MACs and forward port; misses are steered to the NIC port.
module fib_lpm_lookup
  import fib_lpm_lookup_pkg::*;
#(
  parameter int unsigned       Entries  = 16,
  parameter logic [PORT_W-1:0] MaxPort  = 4'h3,
  parameter logic [PORT_W-1:0] NicPort  = NIC_PORT_DEF,
  localparam int unsigned      IdxW     = $clog2(Entries),
  localparam int unsigned      NumPorts = 32'(MaxPort) + 32'd1
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst,
  input  logic [MAC_W*NumPorts-1:0] int_mac_addr,
  input  logic                      cfg_we,
  input  logic [IdxW-1:0]           cfg_idx,
  input  logic                      cfg_valid,
  input  logic [IP_W-1:0]           cfg_prefix,
  input  logic [PLEN_W-1:0]         cfg_plen,
  input  logic [IP_W-1:0]           cfg_nexthop,
  input  logic [MAC_W-1:0]          cfg_dmac,
  input  logic [PORT_W-1:0]         cfg_port,
  output logic                      cfg_err,
  input  logic                      req,
  input  logic [IP_W-1:0]           search_ip,
  output logic                      ack,
  output logic                      hit,
  output logic [IP_W-1:0]           dest_ip,
  output logic [MAC_W-1:0]          src_mac,
  output logic [MAC_W-1:0]          dest_mac,
  output logic [PORT_W-1:0]         forward_port,
  output logic                      busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  state_t            r_state;
  logic [IdxW-1:0]   r_idx;
  logic [IP_W-1:0]   r_search_ip;
  logic              r_best_found;
  logic [PLEN_W-1:0] r_best_len;
  logic [IP_W-1:0]   r_best_nh;
  logic [MAC_W-1:0]  r_best_dmac;
  logic [PORT_W-1:0] r_best_port;

  logic              r_ack;
  logic              r_hit;
  logic              r_busy;
  logic              r_cfg_err;
  logic [IP_W-1:0]   r_dest_ip;
  logic [MAC_W-1:0]  r_src_mac;
  logic [MAC_W-1:0]  r_dest_mac;
  logic [PORT_W-1:0] r_forward_port;

  logic              w_cfg_reject;
  logic              w_cfg_wr;
  fib_entry_t        w_wr_entry;
  fib_entry_t        w_rd_entry;
  fib_entry_t        w_cur_entry;
  logic              w_match;
  logic              w_better;
  logic [MAC_W-1:0]  w_src_mac;

  assign w_cfg_reject = (cfg_plen > PLEN_MAX) || ((cfg_port > MaxPort) && (cfg_port != NicPort));
  assign w_cfg_wr     = cfg_we && !w_cfg_reject;

  always_comb begin
    w_wr_entry               = '0;
    w_wr_entry.valid         = cfg_valid;
    w_wr_entry.route.prefix  = cfg_prefix;
    w_wr_entry.route.plen    = cfg_plen;
    w_wr_entry.route.nexthop = cfg_nexthop;
    w_wr_entry.route.dmac    = cfg_dmac;
    w_wr_entry.route.port    = cfg_port;
  end

  fib_lpm_lookup_entry_ram #(
    .Entries (Entries),
    .IdxW    (IdxW)
  ) u_entry_ram (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .i_we    (w_cfg_wr),
    .i_waddr (cfg_idx),
    .i_wdata (w_wr_entry),
    .i_raddr (r_idx),
    .o_rdata (w_rd_entry)
  );

  // A write landing on the entry being scanned this cycle is seen by the current lookup.
  assign w_cur_entry = (w_cfg_wr && (cfg_idx == r_idx)) ? w_wr_entry : w_rd_entry;

  assign w_match  = w_cur_entry.valid &&
                    (((r_search_ip ^ w_cur_entry.route.prefix) & plen_mask(w_cur_entry.route.plen)) == '0);
  assign w_better = w_match && (!r_best_found || (w_cur_entry.route.plen > r_best_len));

  // Interface MAC of the winning port; NIC-bound routes have no source MAC.
  always_comb begin
    w_src_mac = '0;
    for (int unsigned p = 0; p < NumPorts; p++) begin
      if (r_best_port == PORT_W'(p)) w_src_mac = int_mac_addr[MAC_W*p +: MAC_W];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_search_ip    <= '0;
      r_best_found   <= 1'b0;
      r_best_len     <= '0;
      r_best_nh      <= '0;
      r_best_dmac    <= '0;
      r_best_port    <= '0;
      r_ack          <= 1'b0;
      r_hit          <= 1'b0;
      r_busy         <= 1'b0;
      r_cfg_err      <= 1'b0;
      r_dest_ip      <= '0;
      r_src_mac      <= '0;
      r_dest_mac     <= '0;
      r_forward_port <= '0;
    end else begin
      r_ack     <= 1'b0;
      r_cfg_err <= cfg_we && w_cfg_reject;
      case (r_state)
        ST_IDLE: begin
          r_busy <= req;
          if (req) begin
            r_search_ip  <= search_ip;
            r_idx        <= '0;
            r_best_found <= 1'b0;
            r_best_len   <= '0;
            r_state      <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_better) begin
            r_best_found <= 1'b1;
            r_best_len   <= w_cur_entry.route.plen;
            r_best_nh    <= w_cur_entry.route.nexthop;
            r_best_dmac  <= w_cur_entry.route.dmac;
            r_best_port  <= w_cur_entry.route.port;
          end
          if (r_idx == IdxW'(Entries - 1)) r_state <= ST_DONE;
          else                             r_idx   <= r_idx + 1'b1;
        end
        ST_DONE: begin
          r_ack          <= 1'b1;
          r_hit          <= r_best_found;
          r_forward_port <= r_best_found ? r_best_port : NicPort;
          r_dest_ip      <= (r_best_found && (r_best_nh != '0)) ? r_best_nh : r_search_ip;
          r_dest_mac     <= r_best_found ? r_best_dmac : '0;
          r_src_mac      <= r_best_found ? w_src_mac : '0;
          r_state        <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign ack          = r_ack;
  assign hit          = r_hit;
  assign busy         = r_busy;
  assign cfg_err      = r_cfg_err;
  assign dest_ip      = r_dest_ip;
  assign src_mac      = r_src_mac;
  assign dest_mac     = r_dest_mac;
  assign forward_port = r_forward_port;

endmodule
